rps_match_controller: RTL
=========================

// Module: rps_match_controller
// PURPOSE
//  Next-generation rock-paper-scissors game core: first-to-WIN_TARGET match against an LFSR-driven CPU opponent.
//  Adds to the single-round controller: button edge detection, per-round reveal timing, score counters,
//  draw indication, match-over latch and a test override of the CPU pick. Sits between board buttons and LEDs/7-seg.
// PARAMETERS
//  WIN_TARGET     3         rounds needed to win the match (1..2**SCORE_W-1)
//  SCORE_W        3         width of each score counter
//  LFSR_W         16        CPU LFSR width (>=8; Galois, maximal-length taps from rps_pkg)
//  LFSR_SEED      16'hACE1  reset value of LFSR (must be non-zero)
//  REVEAL_CYCLES  8         cycles the result LEDs are held per round (>=2)
// PORTS
//  clock            in   1        single clock, all logic rising-edge
//  reset_button     in   1        asynchronous, active-low reset
//  rock_button      in   1        synchronous level, player selects rock
//  paper_button     in   1        synchronous level, player selects paper
//  scissors_button  in   1        synchronous level, player selects scissors
//  stop_signal      in   1        synchronous level, freezes CPU pick / reveals round
//  new_match        in   1        synchronous level, clears scores and starts a match
//  cpu_override_en  in   1        when 1, CPU pick is cpu_override instead of LFSR
//  cpu_override     in   2        forced CPU pick (rps_pkg encoding)
//  win_led          out  1        player won the round (REVEAL only)
//  lose_led         out  1        player lost the round (REVEAL only)
//  draw_led         out  1        round drawn (REVEAL only)
//  cpu_choice       out  2        frozen CPU pick, valid in REVEAL/MATCH_OVER, else 0
//  player_score     out  SCORE_W  player rounds won
//  cpu_score        out  SCORE_W  CPU rounds won
//  match_over       out  1        a side reached WIN_TARGET
//  match_won        out  1        player won the match (valid while match_over)
// BEHAVIOUR
//  Encoding: NONE=0, ROCK=1, PAPER=2, SCISSORS=3. Beats: R>S, P>R, S>P.
//  Reset (async assert, sync deassert handled upstream): state IDLE, LFSR=LFSR_SEED, all outputs 0, edge regs 0.
//  All buttons/stop/new_match are rising-edge detected (1-cycle pulse on 0->1); levels held high act once.
//  LFSR advances every cycle in all states except reset; cpu candidate = (lfsr mod 3)+1.
//  FSM:
//   IDLE: new_match edge -> SELECT, scores cleared.
//   SELECT: exactly one choice edge in a cycle -> latch player choice, go ARMED. >1 simultaneous edges ignored.
//   ARMED: choice edge overwrites latched choice (last wins). stop edge -> freeze cpu pick
//     (override if cpu_override_en), compute result, update score (saturating at WIN_TARGET), go REVEAL.
//     Choice edge and stop edge same cycle: new choice used for the round.
//   REVEAL: exactly one of win/lose/draw_led high for REVEAL_CYCLES cycles; cpu_choice shown.
//     Inputs ignored. On expiry: if a score == WIN_TARGET -> MATCH_OVER, else SELECT (LEDs, cpu_choice -> 0).
//   MATCH_OVER: match_over=1, match_won=(player_score==WIN_TARGET); win/lose_led mirror match_won/!match_won,
//     draw_led=0; scores held. new_match edge -> SELECT with scores 0.
//  new_match edge in SELECT/ARMED: abandon round, clear scores, go SELECT. Ignored in REVEAL.
//  Latency: stop edge at cycle N (registered input at N) -> LEDs valid at N+1; score updated at N+1.
//  Draw does not change either score. Reset mid-round returns to IDLE immediately, scores 0.
// STRUCTURE
//  rps_pkg: choice encoding localparams, state encoding, LFSR tap constants, function beats(a,b).
//  Sub-module rps_edge_detect (vector width param) for the five input edge pulses; FSM, LFSR, scores in top.
// TESTING
//  1 Reset low mid-ARMED -> next cycle all outputs 0, state IDLE; release, new_match -> SELECT, scores 0.
//  2 Override PAPER, press rock, stop -> lose_led=1 for exactly 8 cycles, cpu_choice=2, cpu_score=1.
//  3 Override ROCK, press rock, stop -> draw_led=1, scores unchanged (0/0).
//  4 Three rounds player wins (S vs override P) -> player_score=3, match_over=1, match_won=1, win_led held.
//  5 rock+paper edges same cycle -> stays SELECT; hold rock high 20 cycles -> one selection only.
//  6 Override off, 1000 rounds, LFSR model in bench -> cpu_choice matches model, never 0, all three seen.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared encodings, FSM states and helper functions for the rock-paper-scissors match core.
package rps_pkg;

  localparam logic [1:0] CH_NONE     = 2'd0;
  localparam logic [1:0] CH_ROCK     = 2'd1;
  localparam logic [1:0] CH_PAPER    = 2'd2;
  localparam logic [1:0] CH_SCISSORS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ARMED,
    ST_REVEAL,
    ST_MATCH_OVER
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_WIN,
    RES_LOSE,
    RES_DRAW
  } result_e;

  // Right-shifting Galois masks for maximal-length polynomials.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'hA300_0000;
      default: return 32'h0000_B400;
    endcase
  endfunction

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == CH_ROCK     && b == CH_SCISSORS) ||
           (a == CH_PAPER    && b == CH_ROCK)     ||
           (a == CH_SCISSORS && b == CH_PAPER);
  endfunction

  // A choice is only taken when exactly one button edge arrives in a cycle.
  function automatic logic [1:0] pick_choice(input logic r, input logic p, input logic s);
    case ({s, p, r})
      3'b001:  return CH_ROCK;
      3'b010:  return CH_PAPER;
      3'b100:  return CH_SCISSORS;
      default: return CH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rps_edge_detect.sv
// Rising-edge pulse generator for a vector of synchronous level inputs.
module rps_edge_detect #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] level,
  output logic [W-1:0] pulse
);

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_d;

  always_comb begin
    prev_d = level;
    pulse  = level & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= prev_d;
  end

endmodule

// File: rtl/rps_match_controller.sv
// First-to-WIN_TARGET rock-paper-scissors match against an LFSR-driven CPU opponent.
module rps_match_controller
  import rps_pkg::*;
#(
  parameter int unsigned        WIN_TARGET    = 3,
  parameter int unsigned        SCORE_W       = 3,
  parameter int unsigned        LFSR_W        = 16,
  parameter logic [LFSR_W-1:0]  LFSR_SEED     = LFSR_W'(16'hACE1),
  parameter int unsigned        REVEAL_CYCLES = 8
) (
  input  logic               clock,
  input  logic               reset_button,
  input  logic               rock_button,
  input  logic               paper_button,
  input  logic               scissors_button,
  input  logic               stop_signal,
  input  logic               new_match,
  input  logic               cpu_override_en,
  input  logic [1:0]         cpu_override,
  output logic               win_led,
  output logic               lose_led,
  output logic               draw_led,
  output logic [1:0]         cpu_choice,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] cpu_score,
  output logic               match_over,
  output logic               match_won
);

  localparam int unsigned       CNT_W  = $clog2(REVEAL_CYCLES);
  localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REVEAL_CYCLES - 1);

  logic [4:0] pulse;
  logic       rock_p, paper_p, scissors_p, stop_p, new_p;

  rps_edge_detect #(.W(5)) u_edge (
    .clk   (clock),
    .rst_n (reset_button),
    .level ({new_match, stop_signal, scissors_button, paper_button, rock_button}),
    .pulse (pulse)
  );

  assign {new_p, stop_p, scissors_p, paper_p, rock_p} = pulse;

  state_e              state_q, state_d;
  result_e             result_q, result_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [1:0]          choice_q, choice_d;
  logic [1:0]          cpu_q, cpu_d;
  logic [SCORE_W-1:0]  pscore_q, pscore_d;
  logic [SCORE_W-1:0]  cscore_q, cscore_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [1:0] pick;
  logic [1:0] cpu_cand;
  logic [1:0] round_choice;
  logic [1:0] cpu_pick;

  assign pick     = pick_choice(rock_p, paper_p, scissors_p);
  assign cpu_cand = 2'(lfsr_q % LFSR_W'(3)) + 2'd1;

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      state_q  <= ST_IDLE;
      result_q <= RES_NONE;
      lfsr_q   <= LFSR_SEED;
      choice_q <= CH_NONE;
      cpu_q    <= CH_NONE;
      pscore_q <= '0;
      cscore_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      lfsr_q   <= lfsr_d;
      choice_q <= choice_d;
      cpu_q    <= cpu_d;
      pscore_q <= pscore_d;
      cscore_q <= cscore_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    choice_d     = choice_q;
    cpu_d        = cpu_q;
    pscore_d     = pscore_q;
    cscore_d     = cscore_q;
    cnt_d        = cnt_q;
    round_choice = choice_q;
    cpu_pick     = cpu_override_en ? cpu_override : cpu_cand;

    case (state_q)
      ST_IDLE: begin
        if (new_p) begin
          state_d  = ST_SELECT;
          pscore_d = '0;
          cscore_d = '0;
        end
      end
      ST_SELECT: begin
        if (new_p) begin
          pscore_d = '0;
          cscore_d = '0;
        end else if (pick != CH_NONE) begin
          choice_d = pick;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (new_p) begin
          state_d  = ST_SELECT;
          choice_d = CH_NONE;
          pscore_d = '0;
          cscore_d = '0;
        end else begin
          // A choice edge coinciding with stop still counts for this round.
          if (pick != CH_NONE) round_choice = pick;
          choice_d = round_choice;
          if (stop_p) begin
            cpu_d   = cpu_pick;
            cnt_d   = '0;
            state_d = ST_REVEAL;
            if (beats(round_choice, cpu_pick)) begin
              result_d = RES_WIN;
              if (pscore_q < TARGET) pscore_d = pscore_q + SCORE_W'(1);
            end else if (beats(cpu_pick, round_choice)) begin
              result_d = RES_LOSE;
              if (cscore_q < TARGET) cscore_d = cscore_q + SCORE_W'(1);
            end else begin
              result_d = RES_DRAW;
            end
          end
        end
      end
      ST_REVEAL: begin
        if (cnt_q == CNT_LAST) begin
          result_d = RES_NONE;
          choice_d = CH_NONE;
          if (pscore_q == TARGET || cscore_q == TARGET) begin
            state_d = ST_MATCH_OVER;
          end else begin
            state_d = ST_SELECT;
            cpu_d   = CH_NONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MATCH_OVER: begin
        if (new_p) begin
          state_d  = ST_SELECT;
          cpu_d    = CH_NONE;
          pscore_d = '0;
          cscore_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    win_led    = 1'b0;
    lose_led   = 1'b0;
    draw_led   = 1'b0;
    cpu_choice = CH_NONE;
    match_over = 1'b0;
    match_won  = 1'b0;
    case (state_q)
      ST_REVEAL: begin
        win_led    = (result_q == RES_WIN);
        lose_led   = (result_q == RES_LOSE);
        draw_led   = (result_q == RES_DRAW);
        cpu_choice = cpu_q;
      end
      ST_MATCH_OVER: begin
        match_over = 1'b1;
        match_won  = (pscore_q == TARGET);
        win_led    = (pscore_q == TARGET);
        lose_led   = (pscore_q != TARGET);
        cpu_choice = cpu_q;
      end
      default: ;
    endcase
  end

  assign player_score = pscore_q;
  assign cpu_score    = cscore_q;

endmodule
